// File: rtl/cla_sub_64_pipe.sv
// cla_sub_64_pipe: pipelined A - B - Bin as A + ~B + ~Bin, one CLA slice per stage, valid/ready on both ends.
// Optional signed-overflow output ovf when CLA_SUB_OVF_FLAG_EN is defined.
module cla_sub_64_pipe #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
`ifdef CLA_SUB_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);
  localparam int STAGES = WIDTH / SLICE;
  localparam int L = STAGES - 1;

  function automatic logic [SLICE:0] cla(input logic [SLICE-1:0] x, input logic [SLICE-1:0] y, input logic ci);
    logic [SLICE-1:0] g, p;
    logic [SLICE:0] c;
    g = x & y;
    p = x ^ y;
    c = '0;
    c[0] = ci;
    // 4-bit lookahead groups, each group carry-out feeds the next group
    for (int j = 0; j < SLICE; j += 4) begin
      c[j+1] = g[j] | (p[j] & c[j]);
      c[j+2] = g[j+1] | (p[j+1] & g[j]) | (p[j+1] & p[j] & c[j]);
      c[j+3] = g[j+2] | (p[j+2] & g[j+1]) | (p[j+2] & p[j+1] & g[j]) | (p[j+2] & p[j+1] & p[j] & c[j]);
      c[j+4] = g[j+3] | (p[j+3] & g[j+2]) | (p[j+3] & p[j+2] & g[j+1]) | (p[j+3] & p[j+2] & p[j+1] & g[j]) | (&p[j+:4] & c[j]);
    end
    return {c[SLICE], p ^ c[SLICE-1:0]};
  endfunction

  logic [STAGES-1:0] v, adv, ld, c_r, xc, nc;
  logic [STAGES-1:0][WIDTH-1:0] a_r, b_r, d_r, xa, xb, xd, nd;
  logic [SLICE:0] s;
  logic bout_r, zero_r;
`ifdef CLA_SUB_OVF_FLAG_EN
  logic ovf_r;
  assign ovf = ovf_r;
`endif

  always_comb begin
    adv = '0;
    ld = '0;
    xa = '0;
    xb = '0;
    xd = '0;
    xc = '0;
    nd = '0;
    nc = '0;
    s = '0;
    adv[L] = v[L] & out_ready;
    for (int k = L - 1; k >= 0; k--) adv[k] = v[k] & (~v[k+1] | adv[k+1]);
    in_ready = ~v[0] | adv[0];
    ld[0] = in_valid & in_ready;
    xa[0] = a;
    xb[0] = ~b;
    xc[0] = ~bin;
    for (int k = 1; k < STAGES; k++) begin
      ld[k] = adv[k-1];
      xa[k] = a_r[k-1];
      xb[k] = b_r[k-1];
      xd[k] = d_r[k-1];
      xc[k] = c_r[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      s = cla(xa[k][k*SLICE +: SLICE], xb[k][k*SLICE +: SLICE], xc[k]);
      nd[k] = xd[k];
      nd[k][k*SLICE +: SLICE] = s[SLICE-1:0];
      nc[k] = s[SLICE];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      a_r <= '0;
      b_r <= '0;
      d_r <= '0;
      c_r <= '0;
      bout_r <= 1'b0;
      zero_r <= 1'b0;
`ifdef CLA_SUB_OVF_FLAG_EN
      ovf_r <= 1'b0;
`endif
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        v[k] <= ld[k] | (v[k] & ~adv[k]);
        if (ld[k]) begin
          a_r[k] <= xa[k];
          b_r[k] <= xb[k];
          d_r[k] <= nd[k];
          c_r[k] <= nc[k];
        end
      end
      if (ld[L]) begin
        bout_r <= ~nc[L];
        zero_r <= nd[L] == '0;
`ifdef CLA_SUB_OVF_FLAG_EN
        ovf_r <= (xa[L][WIDTH-1] ^ ~xb[L][WIDTH-1]) & (nd[L][WIDTH-1] ^ xa[L][WIDTH-1]);
`endif
      end
    end
  end

  assign out_valid = v[L];
  assign diff = d_r[L];
  assign bout = bout_r;
  assign zero = zero_r;
endmodule
